// File: rtl/mem_arbiter_rr_pkg.sv
// rtl/mem_arbiter_rr_pkg.sv - shared sizing helpers and parameter range checks for mem_arbiter_rr
package mem_arbiter_rr_pkg;

    localparam int NCORES_MIN = 2;
    localparam int NCORES_MAX = 16;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Read tag record: {valid, requester index}
    function automatic int tag_w(input int ncores);
        return 1 + clog2(ncores);
    endfunction

    function automatic bit ncores_ok(input int n);
        return (n >= NCORES_MIN) && (n <= NCORES_MAX);
    endfunction

    function automatic bit rd_lat_ok(input int n);
        return (n >= RD_LAT_MIN) && (n <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_rr_picker.sv
// rtl/mem_arbiter_rr_rr_picker.sv - combinational round-robin pick starting at ptr
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] win_o,
    output logic          any_o
);

    logic [N-1:0] rot;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then map back.
    always_comb begin
        rot   = '0;
        win_o = '0;
        for (int k = 0; k < N; k++) begin
            rot[k] = req_i[(k + int'(ptr_i)) % N];
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win_o = IW'((k + int'(ptr_i)) % N);
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - round-robin arbiter sharing one single-port RAM among NCORES requesters
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NCORES   = 4,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 4
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic [NCORES-1:0]    rden,
    input  logic [NCORES-1:0]    wren,
    input  logic [NCORES-1:0]    lock,
    input  logic [NCORES*AW-1:0] Address,
    input  logic [NCORES*DW-1:0] Din,
    input  logic [DW-1:0]        RAMq,
    output logic [NCORES-1:0]    acq,
    output logic [NCORES*DW-1:0] Dq,
    output logic [NCORES-1:0]    dvalid,
    output logic [AW-1:0]        RAMAddress,
    output logic [DW-1:0]        RAMDin,
    output logic                 RAMwren,
    output logic                 RAMrden,
    output logic [NCORES-1:0]    conflict
);

    localparam int IW = clog2(NCORES);
    localparam int TW = tag_w(NCORES);
    localparam int CW = clog2(LOCK_MAX) + 1;

    if (!ncores_ok(NCORES)) begin : g_bad_ncores
        $error("mem_arbiter_rr: NCORES out of range");
    end
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("mem_arbiter_rr: RD_LAT out of range");
    end

    logic [NCORES-1:0] req;
    logic [IW-1:0]     rr_win;
    logic              any_req;
    logic              lock_hold;
    logic              same_owner;
    logic [IW-1:0]     win;
    logic [NCORES-1:0] win_onehot;
    logic [IW-1:0]     ptr_d;
    logic [CW-1:0]     lockcnt_d;

    logic [NCORES-1:0] acq_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     owner_q;
    logic [CW-1:0]     lockcnt_q;
    logic [AW-1:0]     ramaddr_q;
    logic [DW-1:0]     ramdin_q;
    logic              ramwren_q;
    logic              ramrden_q;
    logic [NCORES-1:0] conflict_q;
    logic [TW-1:0]     tag_q [RD_LAT];
    logic [DW-1:0]     hold_q [NCORES];

    assign req = rden | wren;

    rr_picker #(
        .N  (NCORES),
        .IW (IW)
    ) u_picker (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (rr_win),
        .any_o (any_req)
    );

    always_comb begin
        lock_hold  = acq_q[owner_q] & req[owner_q] & lock[owner_q]
                   & (lockcnt_q < CW'(LOCK_MAX - 1));
        win        = lock_hold ? owner_q : rr_win;
        same_owner = (|acq_q) && (win == owner_q);
        win_onehot = '0;
        win_onehot[win] = 1'b1;
        ptr_d      = (win == IW'(NCORES - 1)) ? '0 : win + 1'b1;
        // An expired lock restarts the count even when the owner wins again.
        lockcnt_d  = (same_owner && (lockcnt_q < CW'(LOCK_MAX - 1))) ? lockcnt_q + 1'b1 : '0;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acq_q      <= '0;
            ptr_q      <= '0;
            owner_q    <= '0;
            lockcnt_q  <= '0;
            ramaddr_q  <= '0;
            ramdin_q   <= '0;
            ramwren_q  <= 1'b0;
            ramrden_q  <= 1'b0;
            conflict_q <= '0;
        end else if (any_req) begin
            acq_q     <= win_onehot;
            ptr_q     <= ptr_d;
            owner_q   <= win;
            lockcnt_q <= lockcnt_d;
            ramaddr_q <= Address[int'(win)*AW +: AW];
            ramdin_q  <= Din[int'(win)*DW +: DW];
            ramwren_q <= wren[win];
            ramrden_q <= rden[win] & ~wren[win];
            if (rden[win] & wren[win]) begin
                conflict_q[win] <= 1'b1;
            end
        end else begin
            acq_q     <= '0;
            lockcnt_q <= '0;
            ramwren_q <= 1'b0;
            ramrden_q <= 1'b0;
        end
    end

    // owner_q names the requester whose read is on the RAM bus this cycle.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RD_LAT; s++) begin
                tag_q[s] <= '0;
            end
            for (int i = 0; i < NCORES; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= {ramrden_q, owner_q};
            for (int s = 1; s < RD_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            for (int i = 0; i < NCORES; i++) begin
                if (dvalid[i]) begin
                    hold_q[i] <= RAMq;
                end
            end
        end
    end

    always_comb begin
        dvalid = '0;
        if (tag_q[RD_LAT-1][TW-1]) begin
            dvalid[tag_q[RD_LAT-1][IW-1:0]] = 1'b1;
        end
    end

    for (genvar i = 0; i < NCORES; i++) begin : g_dq
        assign Dq[i*DW +: DW] = dvalid[i] ? RAMq : hold_q[i];
    end

    assign acq        = acq_q;
    assign RAMAddress = ramaddr_q;
    assign RAMDin     = ramdin_q;
    assign RAMwren    = ramwren_q;
    assign RAMrden    = ramrden_q;
    assign conflict   = conflict_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - directed self-checking bench for mem_arbiter_rr
module tb_mem_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            CLK = 1'b0;
    logic            rst_n;
    logic [N-1:0]    rden, wren, lock;
    logic [N*AW-1:0] Address;
    logic [N*DW-1:0] Din;
    logic [DW-1:0]   RAMq = '0;
    logic [N-1:0]    acq, dvalid, conflict;
    logic [N*DW-1:0] Dq;
    logic [AW-1:0]   RAMAddress;
    logic [DW-1:0]   RAMDin;
    logic            RAMwren, RAMrden;

    int tests = 0;
    int errs  = 0;

    mem_arbiter_rr #(
        .NCORES(N), .AW(AW), .DW(DW), .RD_LAT(1), .LOCK_MAX(4)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .rden(rden), .wren(wren), .lock(lock),
        .Address(Address), .Din(Din), .RAMq(RAMq), .acq(acq), .Dq(Dq),
        .dvalid(dvalid), .RAMAddress(RAMAddress), .RAMDin(RAMDin),
        .RAMwren(RAMwren), .RAMrden(RAMrden), .conflict(conflict)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : a + 8'h40;
    endfunction

    bit [7:0] mem [256];
    bit       wr_valid [256];
    always @(posedge CLK) begin
        if (RAMwren) begin
            mem[RAMAddress]      <= RAMDin;
            wr_valid[RAMAddress] <= 1'b1;
        end
        if (RAMrden) begin
            RAMq <= wr_valid[RAMAddress] ? mem[RAMAddress] : rom(RAMAddress);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        rden = '0; wren = '0; lock = '0; Address = '0; Din = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".acq"}, 32'(acq), 0);
        check({tag, ".dvalid"}, 32'(dvalid), 0);
        check({tag, ".conflict"}, 32'(conflict), 0);
        check({tag, ".Dq"}, 32'(Dq), 0);
        check({tag, ".RAMAddress"}, 32'(RAMAddress), 0);
        check({tag, ".RAMDin"}, 32'(RAMDin), 0);
        check({tag, ".RAMwren"}, 32'(RAMwren), 0);
        check({tag, ".RAMrden"}, 32'(RAMrden), 0);
    endtask

    logic [3:0] seq4 [5];
    logic [3:0] lock_seq [10];

    initial begin
        seq4     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        lock_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000,
                     4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
        clear_in();
        do_reset();
        check_all_zero("reset");

        // Single read by core 2
        rden[2] = 1'b1;
        Address[2*AW +: AW] = 8'h10;
        tick();
        check("rd1.acq", 32'(acq), 32'b0100);
        check("rd1.RAMAddress", 32'(RAMAddress), 32'h10);
        check("rd1.RAMrden", 32'(RAMrden), 1);
        check("rd1.dvalid_early", 32'(dvalid), 0);
        clear_in();
        tick();
        check("rd1.dvalid", 32'(dvalid), 32'b0100);
        check("rd1.Dq2", 32'(Dq[2*DW +: DW]), 32'hA5);
        tick();
        check("rd1.dvalid_off", 32'(dvalid), 0);
        check("rd1.Dq2_hold", 32'(Dq[2*DW +: DW]), 32'hA5);
        check("rd1.acq_idle", 32'(acq), 0);

        // All four cores reading continuously
        do_reset();
        rden = 4'b1111;
        for (int i = 0; i < N; i++) Address[i*AW +: AW] = 8'(8'h20 + i);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr.acq%0d", k), 32'(acq), 32'(seq4[k]));
            if (k >= 1) begin
                check($sformatf("rr.dvalid%0d", k), 32'(dvalid), 32'(seq4[k-1]));
            end
            if (k == 4) clear_in();
        end
        tick();
        check("rr.dvalid_last", 32'(dvalid), 32'b0001);
        check("rr.acq_idle", 32'(acq), 0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rr.Dq%0d", i), 32'(Dq[i*DW +: DW]), 32'(8'h60 + i));
        end

        // Lock by core 1 against core 3
        do_reset();
        rden = 4'b1010;
        lock = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("lock.acq%0d", k), 32'(acq), 32'(lock_seq[k]));
        end
        clear_in();
        tick();
        tick();

        // Read/write conflict on core 0
        do_reset();
        rden[0] = 1'b1;
        wren[0] = 1'b1;
        Address[0 +: AW] = 8'h05;
        Din[0 +: DW] = 8'h3C;
        tick();
        check("cf.acq", 32'(acq), 32'b0001);
        check("cf.RAMwren", 32'(RAMwren), 1);
        check("cf.RAMrden", 32'(RAMrden), 0);
        check("cf.RAMAddress", 32'(RAMAddress), 32'h05);
        check("cf.RAMDin", 32'(RAMDin), 32'h3C);
        check("cf.conflict", 32'(conflict), 32'b0001);
        clear_in();
        tick();
        check("cf.no_dvalid1", 32'(dvalid), 0);
        tick();
        check("cf.no_dvalid2", 32'(dvalid), 0);
        check("cf.sticky", 32'(conflict), 32'b0001);
        rden[2] = 1'b1;
        Address[2*AW +: AW] = 8'h05;
        tick();
        check("cf.rdback_acq", 32'(acq), 32'b0100);
        clear_in();
        tick();
        check("cf.rdback_dvalid", 32'(dvalid), 32'b0100);
        check("cf.rdback_Dq2", 32'(Dq[2*DW +: DW]), 32'h3C);
        check("cf.sticky2", 32'(conflict), 32'b0001);

        // Reset in the middle of a read
        do_reset();
        rden[1] = 1'b1;
        Address[1*AW +: AW] = 8'h10;
        tick();
        check("rst.acq", 32'(acq), 32'b0010);
        check("rst.RAMrden", 32'(RAMrden), 1);
        clear_in();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst.async");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst.no_dvalid1", 32'(dvalid), 0);
        tick();
        check("rst.no_dvalid2", 32'(dvalid), 0);
        rden = 4'b0101;
        tick();
        check("rst.ptr0", 32'(acq), 32'b0001);
        clear_in();
        tick();

        // Idle gap and pointer wrap
        do_reset();
        wren[3] = 1'b1;
        Address[3*AW +: AW] = 8'h33;
        Din[3*DW +: DW] = 8'h77;
        tick();
        check("wrap.acq3", 32'(acq), 32'b1000);
        check("wrap.RAMwren", 32'(RAMwren), 1);
        clear_in();
        tick();
        check("wrap.acq_idle", 32'(acq), 0);
        check("wrap.RAMwren_idle", 32'(RAMwren), 0);
        check("wrap.RAMAddress_hold", 32'(RAMAddress), 32'h33);
        check("wrap.RAMDin_hold", 32'(RAMDin), 32'h77);
        check("wrap.no_dvalid", 32'(dvalid), 0);
        rden = 4'b0101;
        tick();
        check("wrap.acq0", 32'(acq), 32'b0001);
        clear_in();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
